// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bundle for the N-bit sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_nbit_seq_if.sv
// Operand/result handshake bundle of the N-bit ALU; master drives operands, slave is the ALU.
interface alu_nbit_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       operacion;
  logic             invert;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, operacion, invert, out_ready,
    input  in_ready, out_valid, resultado, zero, carry, overflow, negative
  );

  modport slave (
    input  in_valid, a, b, operacion, invert, out_ready,
    output in_ready, out_valid, resultado, zero, carry, overflow, negative
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, keeps the low WIDTH product bits.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;

  // done stays high with a stable product until the next start, so the
  // consumer may collect it late when its output register is still occupied.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start_i) begin
      acc    <= '0;
      mcand  <= a_i;
      mplier <= b_i;
      cnt    <= CW'(WIDTH - 1);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign busy_o = busy;
  assign done_o = done;
  assign prod_o = acc;

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered N-bit ALU with valid/ready on both sides and registered Z/C/V/N flags.
// Define ALU_MUL_EN to make opcode 110 an iterative multiply; otherwise it yields zero.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       operacion_i,
  input  logic             invert_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] resultado_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             negative_o
);

  state_t           state;
  state_t           state_next;
  logic             out_free;
  logic             accept;
  logic             load_alu;
  logic             load;
  logic [WIDTH-1:0] load_res;
  flags_t           load_flags;
  flags_t           flags_q;

  logic [WIDTH-1:0] bx;
  logic             sub_force;
  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH:0]   add_full;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

`ifdef ALU_MUL_EN
  logic             mul_start;
  logic             load_mul;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (mul_start),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );
`endif

  // One shared adder: SLT/SLTU force a subtract regardless of invert_i.
  assign bx        = invert_i ? ~b_i : b_i;
  assign sub_force = (operacion_i == OP_SLT) || (operacion_i == OP_SLTU);
  assign addend    = sub_force ? ~b_i : bx;
  assign cin       = sub_force | invert_i;
  assign add_full  = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
  assign add_ovf   = (a_i[WIDTH-1] == addend[WIDTH-1]) && (add_full[WIDTH-1] != a_i[WIDTH-1]);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res            = '0;
    alu_flags          = '0;
    case (operacion_i)
      OP_AND:  alu_res = a_i & bx;
      OP_OR:   alu_res = a_i | bx;
      OP_ADD: begin
        alu_res            = add_full[WIDTH-1:0];
        alu_flags.carry    = add_full[WIDTH];
        alu_flags.overflow = add_ovf;
      end
      OP_XOR:  alu_res = a_i ^ bx;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, add_full[WIDTH-1] ^ add_ovf};
      OP_SLTU: begin
        alu_res         = {{(WIDTH-1){1'b0}}, ~add_full[WIDTH]};
        alu_flags.carry = add_full[WIDTH];
      end
      OP_SLL:  alu_res = a_i << b_i[SHW-1:0];
      default: alu_res = '0;
    endcase
    alu_flags.zero     = (alu_res == '0);
    alu_flags.negative = alu_res[WIDTH-1];
  end

  assign out_free   = ~out_valid_o | out_ready_i;
  assign in_ready_o = (state == ST_IDLE) && out_free;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
`ifdef ALU_MUL_EN
    mul_start  = 1'b0;
    load_mul   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        load_alu = accept;
`ifdef ALU_MUL_EN
        if (accept && operacion_i == OP_MUL) begin
          load_alu   = 1'b0;
          mul_start  = 1'b1;
          state_next = ST_BUSY;
        end
`endif
      end
      ST_BUSY: begin
`ifdef ALU_MUL_EN
        // A finished product waits here until the output register frees up.
        if (mul_done && !mul_busy && out_free) begin
          load_mul   = 1'b1;
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load       = load_alu;
    load_res   = alu_res;
    load_flags = alu_flags;
`ifdef ALU_MUL_EN
    if (load_mul) begin
      load                = 1'b1;
      load_res            = mul_prod;
      load_flags          = '0;
      load_flags.zero     = (mul_prod == '0);
      load_flags.negative = mul_prod[WIDTH-1];
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  // NOTE: the data/flag registers are reset too, because the cleared result is externally visible.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      resultado_o <= '0;
      flags_q     <= '0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      resultado_o <= load_res;
      flags_q     <= load_flags;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign zero_o     = flags_q.zero;
  assign carry_o    = flags_q.carry;
  assign overflow_o = flags_q.overflow;
  assign negative_o = flags_q.negative;

endmodule
